// File: rtl/k12a_ram_ctrl_if.sv
// rtl/k12a_ram_ctrl_if.sv - request/response bundle between the memory arbiter and the SRAM controller
// The arbiter is the master; the controller is the slave.
interface k12a_ram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [14:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/k12a_ram_ctrl.sv
// rtl/k12a_ram_ctrl.sv - single-byte initiator for a 62256-style asynchronous SRAM
// Every SRAM pin and the bus driver enable come straight from flops.
module k12a_ram_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  k12a_ram_ctrl_if.slave       req,
  output logic [14:0]          ram_addr,
  inout  wire  [7:0]           ram_data,
  output logic                 ram_ce_n,
  output logic                 ram_oe_n,
  output logic                 ram_we_n
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] wait_cnt;
  logic       is_write;
  logic [7:0] wdata_q;
  logic       drive_en;
  logic       resp_valid_q;
  logic [7:0] resp_rdata_q;

  assign req.req_ready  = (state == ST_IDLE);
  assign req.resp_valid = resp_valid_q;
  assign req.resp_rdata = resp_rdata_q;

  // Write data stays on the bus from SETUP through HOLD so it brackets we_n on both sides.
  assign ram_data = drive_en ? wdata_q : 8'hzz;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      wait_cnt     <= 4'd0;
      is_write     <= 1'b0;
      wdata_q      <= 8'd0;
      drive_en     <= 1'b0;
      ram_addr     <= 15'd0;
      ram_ce_n     <= 1'b1;
      ram_oe_n     <= 1'b1;
      ram_we_n     <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req.req_valid) begin
            state    <= ST_SETUP;
            is_write <= req.req_write;
            wdata_q  <= req.req_wdata;
            ram_addr <= req.req_addr;
            ram_ce_n <= 1'b0;
            drive_en <= req.req_write;
          end
        end
        ST_SETUP: begin
          state    <= ST_ACCESS;
          wait_cnt <= WAIT_LOAD;
          if (is_write) begin
            ram_we_n <= 1'b0;
          end else begin
            ram_oe_n <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state        <= ST_HOLD;
            ram_oe_n     <= 1'b1;
            ram_we_n     <= 1'b1;
            resp_valid_q <= 1'b1;
            // Sample on the same edge that raises oe_n, while the SRAM still drives.
            if (!is_write) begin
              resp_rdata_q <= ram_data;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          ram_ce_n     <= 1'b1;
          drive_en     <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k12a_ram_ctrl.sv
// tb/tb_k12a_ram_ctrl.sv - bench for k12a_ram_ctrl at WAIT_CYCLES 2, 1 and 15
// Each controller drives its own behavioural SRAM; expected data comes from a per-instance byte array.
module tb_k12a_ram_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  int          wait_a [3] = '{2, 1, 15};
  logic        rstn [3];
  logic        req_valid_a [3];
  logic        req_write_a [3];
  logic [14:0] req_addr_a [3];
  logic [7:0]  req_wdata_a [3];
  logic        req_ready_a [3];
  logic        resp_valid_a [3];
  logic [7:0]  resp_rdata_a [3];
  logic        ce_a [3];
  logic        oe_a [3];
  logic        we_a [3];
  logic [14:0] addr_a [3];

  logic [7:0]  ref_mem [3][32768];
  bit          ref_vld [3][32768];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    k12a_ram_ctrl_if bus ();
    wire  [7:0]  ram_data;
    logic [14:0] ram_addr;
    logic        ram_ce_n, ram_oe_n, ram_we_n;
    logic [7:0]  mem [32768];

    assign bus.req_valid   = req_valid_a[g];
    assign bus.req_write   = req_write_a[g];
    assign bus.req_addr    = req_addr_a[g];
    assign bus.req_wdata   = req_wdata_a[g];
    assign req_ready_a[g]  = bus.req_ready;
    assign resp_valid_a[g] = bus.resp_valid;
    assign resp_rdata_a[g] = bus.resp_rdata;
    assign ce_a[g]   = ram_ce_n;
    assign oe_a[g]   = ram_oe_n;
    assign we_a[g]   = ram_we_n;
    assign addr_a[g] = ram_addr;

    assign ram_data = (!ram_ce_n && !ram_oe_n && ram_we_n) ? mem[ram_addr] : 8'hzz;
    always @(posedge ram_we_n) if (!ram_ce_n) mem[ram_addr] = ram_data;

    k12a_ram_ctrl #(.WAIT_CYCLES(W)) u_dut (
      .clock    (clock),
      .reset_n  (rstn[g]),
      .req      (bus),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .ram_ce_n (ram_ce_n),
      .ram_oe_n (ram_oe_n),
      .ram_we_n (ram_we_n)
    );

    int proto_err = 0;
    int resp_orphan = 0;
    int outstanding = 0;
    int oe_run = 0;
    int we_run = 0;
    logic prev_oe = 1'b1, prev_we = 1'b1, prev_ce = 1'b1;
    logic [14:0] prev_addr = '0;

    always @(negedge clock) begin
      if (!rstn[g]) begin
        outstanding = 0; oe_run = 0; we_run = 0;
        prev_oe = 1'b1; prev_we = 1'b1; prev_ce = 1'b1;
      end else begin
        if (!ram_oe_n && !ram_we_n) proto_err++;
        if (!ram_oe_n && ram_data !== mem[ram_addr]) proto_err++;
        if (ram_ce_n && ram_data !== 8'hzz) proto_err++;
        if (!ram_ce_n && ram_we_n && ram_oe_n && prev_oe && !prev_ce && ram_data === 8'hzz && we_run == 0 && oe_run != 0) proto_err++;
        // Address and ce_n must already be set when a strobe falls, and still set when it rises.
        if ((prev_oe && prev_we) && !(ram_oe_n && ram_we_n) && (prev_ce || prev_addr != ram_addr)) proto_err++;
        if (!(prev_oe && prev_we) && (ram_oe_n && ram_we_n) && (ram_ce_n || prev_addr != ram_addr)) proto_err++;
        if (!ram_oe_n) oe_run++;
        else if (!prev_oe) begin if (oe_run != W) proto_err++; oe_run = 0; end
        if (!ram_we_n) we_run++;
        else if (!prev_we) begin if (we_run != W) proto_err++; we_run = 0; end
        if (bus.resp_valid) begin
          if (outstanding == 0) resp_orphan++;
          else outstanding--;
        end
        if (bus.req_valid && bus.req_ready) outstanding++;
        prev_oe = ram_oe_n; prev_we = ram_we_n; prev_ce = ram_ce_n; prev_addr = ram_addr;
      end
    end
  end

  // One transaction, entered and left on a negedge; checks latency, ready and read data.
  task automatic txn(input int i, input bit wr, input logic [14:0] a, input logic [7:0] d);
    int n;
    bit rdy_hi;
    logic [7:0] exp;
    exp = ref_mem[i][a];
    req_valid_a[i] = 1'b1; req_write_a[i] = wr; req_addr_a[i] = a; req_wdata_a[i] = d;
    n = 0;
    while (!req_ready_a[i] && n < 50) begin @(negedge clock); n++; end
    check("hs_timeout", 32'(n >= 50), 0);
    @(negedge clock);
    req_valid_a[i] = 1'b0; req_write_a[i] = 1'($urandom);
    req_addr_a[i] = 15'($urandom); req_wdata_a[i] = 8'($urandom);
    n = 1; rdy_hi = 0;
    while (!resp_valid_a[i] && n < 40) begin
      if (req_ready_a[i]) rdy_hi = 1;
      @(negedge clock); n++;
    end
    if (req_ready_a[i]) rdy_hi = 1;
    check("resp_latency", n, 2 + wait_a[i]);
    check("ready_in_txn", 32'(rdy_hi), 0);
    if (wr) begin
      ref_mem[i][a] = d; ref_vld[i][a] = 1;
    end else begin
      check("read_data", resp_rdata_a[i], exp);
    end
  endtask

  task automatic run_random(input int i, input int n);
    logic [14:0] a;
    bit wr;
    for (int k = 0; k < n; k++) begin
      a  = 15'($urandom_range(0, 31) * 1021);
      wr = ($urandom_range(0, 1) == 1) || !ref_vld[i][a];
      txn(i, wr, a, 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, hs, rsp, cyc, ce_hi, rdy_cnt, rv_cnt;
    int hs_cyc [3];
    logic [14:0] b2b [3];
    bit took;
    w0 = wait_a[0];
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 1'b0; req_valid_a[i] = 1'b0; req_write_a[i] = 1'b0;
      req_addr_a[i] = '0; req_wdata_a[i] = '0;
    end
    repeat (2) @(negedge clock);
    check("rst_pins", {ce_a[0], oe_a[0], we_a[0], resp_valid_a[0], req_ready_a[0]}, 5'b11101);
    check("rst_bus", 32'(g_inst[0].ram_data === 8'hzz), 1);
    check("rst_addr", addr_a[0], 0);
    check("rst_rdata", resp_rdata_a[0], 0);
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
    @(negedge clock);

    req_valid_a[0] = 1'b1; req_write_a[0] = 1'b1; req_addr_a[0] = 15'h1234; req_wdata_a[0] = 8'h5A;
    check("wr_ready", req_ready_a[0], 1);
    @(negedge clock);
    req_valid_a[0] = 1'b0; req_wdata_a[0] = 8'hC3; req_addr_a[0] = 15'h0F0F;
    for (int k = 1; k <= 3 + w0; k++) begin
      check("wr_pins", {ce_a[0], oe_a[0], we_a[0], resp_valid_a[0], req_ready_a[0]},
            {1'(k > 2 + w0), 1'b1, 1'(!(k >= 2 && k <= 1 + w0)), 1'(k == 2 + w0), 1'(k == 3 + w0)});
      check("wr_addr", addr_a[0], 15'h1234);
      if (k <= 2 + w0) check("wr_data", g_inst[0].ram_data, 8'h5A);
      if (k < 3 + w0) @(negedge clock);
    end
    ref_mem[0][15'h1234] = 8'h5A; ref_vld[0][15'h1234] = 1;
    txn(0, 0, 15'h1234, 8'h00);
    check("rd_1234", resp_rdata_a[0], 8'h5A);

    txn(0, 1, 15'h0000, 8'h01);
    txn(0, 1, 15'h7FFF, 8'hFE);
    txn(0, 0, 15'h0000, 8'h00);
    check("rd_0000", resp_rdata_a[0], 8'h01);
    txn(0, 0, 15'h7FFF, 8'h00);
    check("rd_7fff", resp_rdata_a[0], 8'hFE);

    b2b = '{15'h1234, 15'h7FFF, 15'h0000};
    @(negedge clock);
    req_valid_a[0] = 1'b1; req_write_a[0] = 1'b0; req_addr_a[0] = b2b[0];
    hs = 0; rsp = 0; cyc = 0; ce_hi = 0; rdy_cnt = 0;
    while ((hs < 3 || rsp < 3) && cyc < 60) begin
      if (resp_valid_a[0]) begin
        check("b2b_data", resp_rdata_a[0], ref_mem[0][b2b[rsp]]);
        rsp++;
      end
      if (hs >= 1 && hs < 3) begin
        if (ce_a[0]) ce_hi++;
        if (req_ready_a[0]) rdy_cnt++;
      end
      took = req_valid_a[0] && req_ready_a[0];
      if (took) begin hs_cyc[hs] = cyc; hs++; end
      @(posedge clock); #1;
      if (took) begin
        if (hs < 3) req_addr_a[0] = b2b[hs];
        else req_valid_a[0] = 1'b0;
      end
      @(negedge clock); cyc++;
    end
    check("b2b_count", {16'(hs), 16'(rsp)}, {16'd3, 16'd3});
    check("b2b_gap1", hs_cyc[1] - hs_cyc[0], 3 + w0);
    check("b2b_gap2", hs_cyc[2] - hs_cyc[1], 3 + w0);
    check("b2b_ce_hi", ce_hi, 2);
    check("b2b_ready_hi", rdy_cnt, 2);

    fork
      run_random(0, 40);
      run_random(1, 40);
      run_random(2, 25);
    join

    @(negedge clock);
    req_valid_a[0] = 1'b1; req_write_a[0] = 1'b1; req_addr_a[0] = 15'h0100; req_wdata_a[0] = 8'h33;
    @(negedge clock);
    req_valid_a[0] = 1'b0;
    @(negedge clock);
    check("rst_pre_we", we_a[0], 0);
    @(posedge clock); #2;
    rstn[0] = 1'b0;
    #1;
    check("rst_async_pins", {ce_a[0], oe_a[0], we_a[0], resp_valid_a[0]}, 4'b1110);
    check("rst_async_bus", 32'(g_inst[0].ram_data === 8'hzz), 1);
    rv_cnt = 0;
    repeat (2) begin @(negedge clock); if (resp_valid_a[0]) rv_cnt++; end
    @(posedge clock); #1;
    rstn[0] = 1'b1;
    @(negedge clock);
    check("rst_release_ready", req_ready_a[0], 1);
    repeat (6) begin if (resp_valid_a[0]) rv_cnt++; @(negedge clock); end
    check("rst_no_resp", rv_cnt, 0);

    check("proto_w2", g_inst[0].proto_err, 0);
    check("proto_w1", g_inst[1].proto_err, 0);
    check("proto_w15", g_inst[2].proto_err, 0);
    check("orphan_w2", g_inst[0].resp_orphan, 0);
    check("orphan_w1", g_inst[1].resp_orphan, 0);
    check("orphan_w15", g_inst[2].resp_orphan, 0);
    check("pending_w1", g_inst[1].outstanding, 0);
    check("pending_w15", g_inst[2].outstanding, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
